// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: round-robin arbiter that lets up to four requesters
// share one SDRAM read port. A single transaction is in flight at a time:
// the winner's address/bank are latched, the request is held until the
// controller accepts it, then the read word is returned with a dok pulse.
// Optional build macro JTFRAME_SDRAM_ARB_TIMEOUT_EN adds an 8-bit watchdog
// that abandons a stalled transaction (dok with unchanged data).
module jtframe_sdram_arb #(
    parameter int AW    = 22,
    parameter int SLOTS = 4
) (
    input  logic                  clk_rom,
    input  logic                  rst,
    input  logic [SLOTS-1:0]      slot_req,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    input  logic [SLOTS*2-1:0]    slot_bank,
    output logic [SLOTS-1:0]      slot_ack,
    output logic [SLOTS-1:0]      slot_dok,
    output logic [31:0]           slot_data,
    output logic                  sdram_req,
    output logic [AW-1:0]         sdram_addr,
    output logic [1:0]            sdram_bank,
    input  logic                  sdram_ack,
    input  logic [31:0]           data_read,
    input  logic                  data_rdy,
    input  logic                  loop_rst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    // rr is the slot with first priority; winner is the slot being served
    logic [1:0]       rr;
    logic [1:0]       winner;
    logic [1:0]       pick;
    logic             found;
    logic [2:0]       cand;
    logic [2:0]       rr_sum;
    logic [1:0]       rr_adv;
    logic [SLOTS-1:0] onehot;

    logic [AW-1:0]    addr_arr [SLOTS];
    logic [1:0]       bank_arr [SLOTS];

    // strobes produced by the FSM and consumed by the register process
    logic             go;
    logic             fire_ack;
    logic             fire_dok;
    logic             ld_data;
    logic             adv;
    logic             timeout;

`ifdef JTFRAME_SDRAM_ARB_TIMEOUT_EN
    logic [7:0]       wdog;

    // watchdog: restarts on entry to REQ or WAIT, counts while busy
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            wdog <= 8'd0;
        end else if ((state == IDLE && state_n == REQ) ||
                     (state == REQ  && state_n == WAIT)) begin
            wdog <= 8'd0;
        end else if (state != IDLE) begin
            wdog <= wdog + 8'd1;
        end
    end

    // fires on the edge where the count reaches 255
    assign timeout = (state != IDLE) && (wdog == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    // unpack per-slot address and bank buses
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_arr[i] = slot_addr[i*AW +: AW];
            bank_arr[i] = slot_bank[i*2 +: 2];
        end
    end

    // round-robin search starting at rr, plus winner decode and next rr
    always_comb begin
        pick   = 2'd0;
        found  = 1'b0;
        cand   = 3'd0;
        for (int i = 0; i < SLOTS; i++) begin
            cand = {1'b0, rr} + 3'(i);
            if (cand >= 3'(SLOTS)) cand = cand - 3'(SLOTS);
            if (!found && slot_req[cand[1:0]]) begin
                found = 1'b1;
                pick  = cand[1:0];
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            onehot[i] = (winner == 2'(i));
        end
        rr_sum = {1'b0, winner} + 3'd1;
        rr_adv = (rr_sum >= 3'(SLOTS)) ? 2'd0 : rr_sum[1:0];
    end

    // state register
    always_ff @(posedge clk_rom) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and transaction strobes; loop_rst aborts without pulses
    always_comb begin
        state_n  = state;
        go       = 1'b0;
        fire_ack = 1'b0;
        fire_dok = 1'b0;
        ld_data  = 1'b0;
        adv      = 1'b0;
        case (state)
            IDLE: begin
                if (found && !loop_rst) begin
                    go      = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (loop_rst) begin
                    state_n = IDLE;
                end else if (sdram_ack) begin
                    fire_ack = 1'b1;
                    if (data_rdy) begin
                        fire_dok = 1'b1;
                        ld_data  = 1'b1;
                        adv      = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n  = WAIT;
                    end
                end else if (timeout) begin
                    fire_dok = 1'b1;
                    adv      = 1'b1;
                    state_n  = IDLE;
                end
            end
            WAIT: begin
                if (loop_rst) begin
                    state_n = IDLE;
                end else if (data_rdy) begin
                    fire_dok = 1'b1;
                    ld_data  = 1'b1;
                    adv      = 1'b1;
                    state_n  = IDLE;
                end else if (timeout) begin
                    fire_dok = 1'b1;
                    adv      = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // registered outputs, latched winner and round-robin pointer
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_bank <= 2'd0;
            slot_ack   <= '0;
            slot_dok   <= '0;
            slot_data  <= 32'd0;
            winner     <= 2'd0;
            rr         <= 2'd0;
        end else begin
            sdram_req <= (state_n == REQ);
            slot_ack  <= fire_ack ? onehot : '0;
            slot_dok  <= fire_dok ? onehot : '0;
            if (go) begin
                winner     <= pick;
                sdram_addr <= addr_arr[pick];
                sdram_bank <= bank_arr[pick];
            end
            if (ld_data) slot_data <= data_read;
            if (adv)     rr        <= rr_adv;
        end
    end

endmodule
